// File: rtl/shd_column_feeder.sv
// Hamming-distance feeder for the windowed SHD accumulator: emits the current
// census HD and the HD from exactly WH*M accepted beats earlier.
module shd_column_feeder #(
  parameter  int WC    = 7,
  parameter  int WH    = 13,
  parameter  int M     = 650,
  localparam int NCB   = (WC**2)/2,
  localparam int NIBIT = $clog2((WC**2)/2)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [NCB-1:0]   i_census_l,
  input  logic [NCB-1:0]   i_census_r,
  input  logic             i_dval,
  output logic [NIBIT-1:0] o_data_l,
  output logic [NIBIT-1:0] o_data_h,
  output logic             o_dval
);

  localparam int D    = WH * M;
  localparam int PW   = $clog2(D + 1);
  localparam int AW   = (D > 1) ? $clog2(D) : 1;
  localparam int CW   = NIBIT + 1;
  localparam int MAXV = (2**NIBIT) - 1;

  logic [NCB-1:0]   x1_q, x1_d;
  logic             v1_q, v1_d;
  logic [NIBIT-1:0] h2_q, h2_d;
  logic             v2_q, v2_d;
  logic [NIBIT-1:0] data_l_q, data_l_d;
  logic [NIBIT-1:0] data_h_q, data_h_d;
  logic             dval_q, dval_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    fill_q, fill_d;

  logic [CW-1:0]    pop;
  logic [NIBIT-1:0] pop_sat;
  logic [NIBIT-1:0] rd_data;
  logic             we;

  // Delay line; never reset, stale contents are masked until fill reaches D.
  logic [NIBIT-1:0] mem [D];

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NCB; i++) begin
      pop = pop + CW'(x1_q[i]);
    end
    pop_sat = (pop > CW'(MAXV)) ? NIBIT'(MAXV) : pop[NIBIT-1:0];
  end

  assign rd_data = mem[ptr_q[AW-1:0]];

  always_comb begin
    x1_d     = x1_q;
    v1_d     = v1_q;
    h2_d     = h2_q;
    v2_d     = v2_q;
    data_l_d = data_l_q;
    data_h_d = data_h_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    dval_d   = 1'b0;
    we       = 1'b0;
    if (i_dval) begin
      x1_d   = i_census_l ^ i_census_r;
      v1_d   = 1'b1;
      h2_d   = pop_sat;
      v2_d   = v1_q;
      dval_d = v2_q;
      if (v2_q) begin
        data_l_d = h2_q;
        data_h_d = (fill_q == PW'(D)) ? rd_data : '0;
        we       = 1'b1;
        ptr_d    = (ptr_q == PW'(D - 1)) ? '0 : ptr_q + 1'b1;
        fill_d   = (fill_q == PW'(D)) ? fill_q : fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x1_q     <= '0;
      v1_q     <= 1'b0;
      h2_q     <= '0;
      v2_q     <= 1'b0;
      data_l_q <= '0;
      data_h_q <= '0;
      dval_q   <= 1'b0;
      ptr_q    <= '0;
      fill_q   <= '0;
    end else begin
      x1_q     <= x1_d;
      v1_q     <= v1_d;
      h2_q     <= h2_d;
      v2_q     <= v2_d;
      data_l_q <= data_l_d;
      data_h_q <= data_h_d;
      dval_q   <= dval_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Same-edge write after the combinational read gives read-before-write.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[ptr_q[AW-1:0]] <= h2_q;
    end
  end

  assign o_data_l = data_l_q;
  assign o_data_h = data_h_q;
  assign o_dval   = dval_q;

endmodule
